acondicionador_botones: RTL and testbench
=========================================

ACONDICIONADOR_BOTONES -- requirements
Module: acondicionador_botones

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required to accept a level change.
REQ-002 Parameter HOLD_CYCLES, default 25000000: cycles from the initial press pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_CYCLES, default 5000000: cycles between subsequent auto-repeat pulses.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 boton_aumenta_in  input  1  raw increment pushbutton, asynchronous, bouncy, active-high.
REQ-007 boton_disminuye_in  input  1  raw decrement pushbutton, asynchronous, bouncy, active-high.
REQ-008 boton_aumenta  output  1  registered one-cycle increment pulse; drives the minute counter.
REQ-009 boton_disminuye  output  1  registered one-cycle decrement pulse; drives the minute counter.
REQ-010 botones_estables  output  2  debounced levels: bit1 = aumenta, bit0 = disminuye.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each channel SHALL keep a debounced level and a counter that increments while the synchronized level differs from the debounced level and clears to 0 when they match.
REQ-013 The debounced level SHALL toggle when the counter reaches DEBOUNCE_CYCLES; the counter then clears.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced level and the outputs unchanged.
REQ-015 Latency: if edge 0 is the first edge sampling the raw input high and the input stays high, the pulse SHALL be high exactly in the cycle after edge 2+DEBOUNCE_CYCLES.
REQ-016 A debounced 0->1 transition SHALL produce exactly one output pulse of one clk cycle.
REQ-017 A debounced 1->0 transition SHALL produce no pulse.
REQ-018 Per-channel FSM SHALL be: IDLE (debounced 0) -> ESPERA on press pulse -> REPETICION after HOLD_CYCLES; any debounced release returns to IDLE.
REQ-019 In ESPERA, the SHALL emit one pulse when the hold counter reaches HOLD_CYCLES, then enter REPETICION.
REQ-020 In REPETICION, the channel SHALL emit one pulse every REPEAT_CYCLES cycles while debounced high.
REQ-021 While both debounced levels are 1, all press and repeat pulses SHALL be suppressed.
REQ-022 Both channels SHALL return to IDLE when both debounced levels are 1, and SHALL not resume repeating until released and pressed again.
REQ-023 If both channels produce debounced 0->1 in the same cycle, neither SHALL pulse.
REQ-024 boton_aumenta and boton_disminuye SHALL never be high in the same cycle.
REQ-025 Counters SHALL be sized to hold their parameter value and SHALL saturate, never wrap.

Reset
REQ-026 While rst_n is 0, synchronizers, debounced levels, counters, FSMs (IDLE) and all outputs SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-press or mid-repeat SHALL abort the operation immediately with no pulse.
REQ-028 After reset release with a button held, a normal press pulse SHALL follow per REQ-015.

Configuration
REQ-029 With macro AUTOREPEAT_EN defined, REQ-018..REQ-020 SHALL apply.
REQ-030 Without AUTOREPEAT_EN, the ESPERA/REPETICION states and the hold/repeat counters SHALL be absent, and each debounced press SHALL give exactly one pulse.
REQ-031 All other behaviour SHALL be identical with or without AUTOREPEAT_EN.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-032 Clean press of aumenta at edge 0, held 10 cycles -> boton_aumenta high for one cycle after edge 6 only; botones_estables=2'b10.
REQ-033 Bouncy disminuye: 3-cycle high, 1 low, then held -> no pulse for the glitch; one pulse 6 edges after the final rise.
REQ-034 AUTOREPEAT_EN, aumenta held 60 cycles after its first pulse -> repeat pulses at first-pulse+20, +28, +36, +44, +52; none after debounced release.
REQ-035 Both inputs rise at the same edge and hold -> no pulse on either output; botones_estables=2'b11.
REQ-036 rst_n driven low mid-REPETICION, asynchronous to clk -> outputs 0 immediately; button still held at release -> single pulse 6 edges later.

Source files
------------

// File: rtl/acondicionador_botones_if.sv
// Button conditioner bundle: raw pushbutton levels in, conditioned pulses and
// debounced levels out.
interface acondicionador_botones_if;
  logic       boton_aumenta_in;
  logic       boton_disminuye_in;
  logic       boton_aumenta;
  logic       boton_disminuye;
  logic [1:0] botones_estables;

  modport master (
    output boton_aumenta_in, boton_disminuye_in,
    input  boton_aumenta, boton_disminuye, botones_estables
  );
  modport slave (
    input  boton_aumenta_in, boton_disminuye_in,
    output boton_aumenta, boton_disminuye, botones_estables
  );
endinterface

// File: rtl/acondicionador_botones.sv
// Two-channel pushbutton conditioner: synchronise, debounce, one pulse per press.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module acondicionador_botones_canal #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic inhibe,
  output logic estable,
  output logic pulso
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_invalido
    $error("acondicionador_botones: cycle parameters must be >= 1");
  end

  logic [1:0]    sincro;
  logic [DW-1:0] cnt;
  logic          estable_prev;
  logic          sube;

  // Counter only runs while the synchronised level disagrees; >= keeps it saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sincro       <= '0;
      cnt          <= '0;
      estable      <= 1'b0;
      estable_prev <= 1'b0;
    end else begin
      sincro       <= {sincro[0], raw};
      estable_prev <= estable;
      if (sincro[1] == estable) begin
        cnt <= '0;
      end else if (cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
        estable <= ~estable;
        cnt     <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  assign sube = estable & ~estable_prev;

`ifdef AUTOREPEAT_EN
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ESPERA, REPETICION} estado_t;
  estado_t       estado;
  logic [TW-1:0] tmr;

  // Release or both-held forces IDLE; a fresh rising edge is needed to restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= IDLE;
      tmr    <= '0;
      pulso  <= 1'b0;
    end else begin
      pulso <= 1'b0;
      if (!estable || inhibe) begin
        estado <= IDLE;
        tmr    <= '0;
      end else begin
        case (estado)
          IDLE: if (sube) begin
            pulso  <= 1'b1;
            estado <= ESPERA;
            tmr    <= '0;
          end
          ESPERA: if (tmr >= TW'(HOLD_CYCLES - 1)) begin
            pulso  <= 1'b1;
            estado <= REPETICION;
            tmr    <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
          REPETICION: if (tmr >= TW'(REPEAT_CYCLES - 1)) begin
            pulso <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulso <= 1'b0;
    else        pulso <= sube & ~inhibe;
  end
`endif
endmodule

module acondicionador_botones #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input logic                      clk,
  input logic                      rst_n,
  acondicionador_botones_if.slave  botones
);
  localparam int NUM_CH = 2;

  // Channel 1 = aumenta, channel 0 = disminuye.
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] estable;
  logic [NUM_CH-1:0] pulso;
  logic              ambos;

  assign raw   = {botones.boton_aumenta_in, botones.boton_disminuye_in};
  assign ambos = &estable;

  acondicionador_botones_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_canal [NUM_CH-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .inhibe  (ambos),
    .estable (estable),
    .pulso   (pulso)
  );

  assign botones.boton_aumenta    = pulso[1];
  assign botones.boton_disminuye  = pulso[0];
  assign botones.botones_estables = estable;
endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with DEBOUNCE=4, HOLD=20, REPEAT=8.
// Auto-repeat expectations follow AUTOREPEAT_EN, matching the DUT build.
module tb_acondicionador_botones;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   both_cnt = 0;

  acondicionador_botones_if bus ();

  acondicionador_botones #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .botones (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.boton_aumenta && bus.boton_disminuye) both_cnt++;

  typedef struct packed {
    logic       a;
    logic       d;
    logic       ea;
    logic       ed;
    logic [1:0] est;
  } vec_t;

  vec_t tbl[$];

  task automatic add_n(input int n, input logic a, input logic d,
                       input logic ea, input logic ed, input logic [1:0] est);
    vec_t v;
    v = '{a: a, d: d, ea: ea, ed: ed, est: est};
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits[$];
    int exp_hits[$];
    int found;
    int cnt;

    bus.boton_aumenta_in   = 1'b0;
    bus.boton_disminuye_in = 1'b0;

    // Reset is asynchronous: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {30'd0, bus.boton_aumenta, bus.boton_disminuye}, 0);
    chk("reset_estables", {30'd0, bus.botones_estables}, 0);
    bus.boton_aumenta_in   = 1'b1;
    bus.boton_disminuye_in = 1'b1;
    repeat (8) edge1();
    chk("reset_held_inputs",
        {29'd0, bus.boton_aumenta, bus.boton_disminuye, |bus.botones_estables}, 0);
    bus.boton_aumenta_in   = 1'b0;
    bus.boton_disminuye_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) edge1();

    // Clean press of aumenta, held 10 cycles, then released.
    add_n(5, 1, 0, 0, 0, 2'b00);
    add_n(1, 1, 0, 0, 0, 2'b10);
    add_n(1, 1, 0, 1, 0, 2'b10);
    add_n(3, 1, 0, 0, 0, 2'b10);
    add_n(5, 0, 0, 0, 0, 2'b10);
    add_n(3, 0, 0, 0, 0, 2'b00);
    // Bouncy disminuye: 3 high, 1 low, then held; pulse 6 edges after final rise.
    add_n(3, 0, 1, 0, 0, 2'b00);
    add_n(1, 0, 0, 0, 0, 2'b00);
    add_n(5, 0, 1, 0, 0, 2'b00);
    add_n(1, 0, 1, 0, 0, 2'b01);
    add_n(1, 0, 1, 0, 1, 2'b01);
    add_n(3, 0, 1, 0, 0, 2'b01);
    add_n(5, 0, 0, 0, 0, 2'b01);
    add_n(3, 0, 0, 0, 0, 2'b00);
    // Both rise together: no pulses, levels 11.
    add_n(5, 1, 1, 0, 0, 2'b00);
    add_n(7, 1, 1, 0, 0, 2'b11);
    add_n(5, 0, 0, 0, 0, 2'b11);
    add_n(3, 0, 0, 0, 0, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.boton_aumenta_in   = tbl[i].a;
      bus.boton_disminuye_in = tbl[i].d;
      edge1();
      chk($sformatf("vec%0d", i),
          {28'd0, bus.boton_aumenta, bus.boton_disminuye, bus.botones_estables},
          {28'd0, tbl[i].ea, tbl[i].ed, tbl[i].est});
    end

    // Long hold: repeat pulse schedule relative to the first pulse.
    bus.boton_aumenta_in = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      edge1();
      if (bus.boton_aumenta) begin found = 1; break; end
    end
    chk("hold_first_pulse", found, 1);
    for (int k = 1; k <= 80; k++) begin
      edge1();
      if (bus.boton_aumenta) hits.push_back(k);
      if (k == 53) bus.boton_aumenta_in = 1'b0;
    end
`ifdef AUTOREPEAT_EN
    exp_hits = '{20, 28, 36, 44, 52};
`endif
    chk("repeat_count", hits.size(), exp_hits.size());
    for (int i = 0; i < exp_hits.size(); i++)
      chk($sformatf("repeat_at%0d", i), (i < hits.size()) ? hits[i] : -1, exp_hits[i]);
    repeat (5) edge1();

    // Async reset while a pulse is high, button held through release.
    bus.boton_aumenta_in = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      edge1();
      if (bus.boton_aumenta) begin found = 1; break; end
    end
`ifdef AUTOREPEAT_EN
    found = 0;
    for (int k = 0; k < 30; k++) begin
      edge1();
      if (bus.boton_aumenta) begin found = 1; break; end
    end
`endif
    chk("pre_reset_pulse", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_pulse", {31'd0, bus.boton_aumenta}, 0);
    chk("async_reset_estables", {30'd0, bus.botones_estables}, 0);
    repeat (2) edge1();
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      edge1();
      if (bus.boton_aumenta !== (k == 6)) cnt++;
    end
    chk("post_reset_press_timing", cnt, 0);

    // aumenta held, disminuye pressed: everything suppressed, no resume after.
    bus.boton_disminuye_in = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      edge1();
      if (bus.boton_aumenta || bus.boton_disminuye) cnt++;
    end
    chk("both_held_no_pulse", cnt, 0);
    chk("both_held_estables", {30'd0, bus.botones_estables}, 32'd3);
    bus.boton_disminuye_in = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      edge1();
      if (bus.boton_aumenta || bus.boton_disminuye) cnt++;
    end
    chk("no_resume_after_both", cnt, 0);
    bus.boton_aumenta_in = 1'b0;
    repeat (10) edge1();

    chk("never_both_pulses", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
